// File: rtl/proj_minhash_sketch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proj_pkg : shared widths, empty-signature constant and sketch FSM states.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package proj_pkg;

    localparam int HASHER_SORTER_SIGNATURE = 32;
    localparam int NUM_HASHES              = 8;
    localparam int SKETCH_IDX_BITS         = $clog2(NUM_HASHES);

    localparam logic [HASHER_SORTER_SIGNATURE-1:0] SIG_EMPTY = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } sketch_state_t;

endpackage
`default_nettype wire

// File: rtl/proj_minhash_sketch_min.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proj_min_cell : one running-minimum register for a single hash function.   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module proj_min_cell #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 upd_en,
    input  logic [DATA_BITS-1:0] in_sig,
    output logic [DATA_BITS-1:0] cur_min
);

    logic [DATA_BITS-1:0] r_min;

    // Strict less-than: an equal signature leaves the stored minimum untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min <= '1;
        end else if (clear) begin
            r_min <= '1;
        end else if (upd_en && (in_sig < r_min)) begin
            r_min <= in_sig;
        end
    end

    assign cur_min = r_min;

endmodule
`default_nettype wire

// File: rtl/proj_minhash_sketch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proj_minhash_sketch : per-seed running minima, drained over valid/ready.   |
// | Optional PROJ_SKETCH_STATS_EN adds a saturating sig_count output.          |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module proj_minhash_sketch #(
    parameter int HASHER_DATA_BITS = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int NUM_HASHES       = proj_pkg::NUM_HASHES,
    parameter int IDX_BITS         = $clog2(NUM_HASHES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_over,
    input  logic                        kmer_full,
    input  logic                        sig_valid,
    input  logic [IDX_BITS-1:0]         sig_idx,
    input  logic [HASHER_DATA_BITS-1:0] signature,
    input  logic                        seq_end,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_BITS-1:0]         out_idx,
    output logic [HASHER_DATA_BITS-1:0] out_min,
    output logic                        done
`ifdef PROJ_SKETCH_STATS_EN
    ,
    output logic [31:0]                 sig_count
`endif
);

    import proj_pkg::*;

    localparam logic [IDX_BITS:0]   NUM_ENTRIES = (IDX_BITS+1)'(NUM_HASHES);
    localparam logic [IDX_BITS-1:0] LAST_IDX    = IDX_BITS'(NUM_HASHES - 1);

    sketch_state_t              r_state;
    logic [IDX_BITS-1:0]        r_cnt;
    logic                       r_out_valid;
    logic [HASHER_DATA_BITS-1:0] r_out_min;
    logic                       r_done;

    logic                       w_accept;
    logic                       w_last_xfer;
    logic                       w_clear;
    logic [IDX_BITS-1:0]        w_rd_idx;
    logic [HASHER_DATA_BITS-1:0] w_rd_min;
    logic [HASHER_DATA_BITS-1:0] w_min [NUM_HASHES];
    logic [NUM_HASHES-1:0]      w_upd;

    // start_over outranks a same-cycle signature, so that signature is dropped.
    assign w_accept = (r_state == ACCUM) && !start_over && sig_valid && kmer_full
                      && ({1'b0, sig_idx} < NUM_ENTRIES);

    assign w_last_xfer = (r_state == DRAIN) && r_out_valid && out_ready
                         && (r_cnt == LAST_IDX);

    assign w_clear = start_over || w_last_xfer;

    generate
        for (genvar gi = 0; gi < NUM_HASHES; gi++) begin : g_cells
            assign w_upd[gi] = w_accept && (sig_idx == IDX_BITS'(gi));

            proj_min_cell #(
                .DATA_BITS (HASHER_DATA_BITS)
            ) u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .clear   (w_clear),
                .upd_en  (w_upd[gi]),
                .in_sig  (signature),
                .cur_min (w_min[gi])
            );
        end
    endgenerate

    // The output register is loaded one entry ahead of the counter on each accept.
    always_comb begin
        w_rd_idx = r_out_valid ? (r_cnt + IDX_BITS'(1)) : r_cnt;
        w_rd_min = '0;
        for (int i = 0; i < NUM_HASHES; i++) begin
            if (w_rd_idx == IDX_BITS'(i)) begin
                w_rd_min = w_min[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_min   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_over) begin
                r_state     <= ACCUM;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
                r_out_min   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    ACCUM: begin
                        if (seq_end) begin
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // First DRAIN cycle reads minima that include the seq_end-cycle signature.
                        if (!r_out_valid) begin
                            r_out_valid <= 1'b1;
                            r_out_min   <= w_rd_min;
                        end else if (out_ready) begin
                            if (r_cnt == LAST_IDX) begin
                                r_done      <= 1'b1;
                                r_out_valid <= 1'b0;
                                r_cnt       <= '0;
                                r_out_min   <= '0;
                                r_state     <= IDLE;
                            end else begin
                                r_cnt     <= w_rd_idx;
                                r_out_min <= w_rd_min;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PROJ_SKETCH_STATS_EN
    logic [31:0] r_sig_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig_count <= '0;
        end else if (w_clear) begin
            r_sig_count <= '0;
        end else if (w_accept && (r_sig_count != '1)) begin
            r_sig_count <= r_sig_count + 32'd1;
        end
    end

    assign sig_count = r_sig_count;
`endif

    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_idx   = r_cnt;
    assign out_min   = r_out_min;
    assign done      = r_done;

endmodule
`default_nettype wire
